// File: rtl/seg7_scan_if.sv
// Bundle of display-side signals between the controller and the seg7_scan driver.
// Master drives the scan clock and data request; slave is the driver itself.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic                  S_CLK;
  logic [4*DIGITS-1:0]   DATA;
  logic [DIGITS-1:0]     DP;
  logic                  LOAD;
  logic                  ACK;
  logic                  FRAME;
  logic [6:0]            SEG;
  logic                  DP_OUT;
  logic [DIGITS-1:0]     AN;

  modport master (
    output S_CLK, DATA, DP, LOAD,
    input  ACK, FRAME, SEG, DP_OUT, AN
  );

  modport slave (
    input  S_CLK, DATA, DP, LOAD,
    output ACK, FRAME, SEG, DP_OUT, AN
  );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: S_CLK edges advance the digit, a guard gap blanks the
// anodes between digits, and the displayed value is reloaded only at frame boundaries.
module seg7_scan #(
  parameter int DIGITS    = 4,
  parameter int GUARD_CYC = 4,
  parameter int BLANK_LZ  = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  seg7_scan_if.slave  bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(GUARD_CYC - 1);

  typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

  state_t              state, nxt_state;
  logic                s1, s2, s3, tick;
  logic [IW-1:0]       idx, nxt_idx, adv_idx;
  logic [CW-1:0]       cnt, nxt_cnt;
  logic [4*DIGITS-1:0] shadow, nxt_shadow;
  logic [DIGITS-1:0]   dp_shadow, nxt_dp_shadow;
  logic                wrap;
  logic                ack_q, frame_q, dp_out_q;
  logic                nxt_ack, nxt_frame, nxt_dp_out;
  logic [6:0]          seg_q, nxt_seg;
  logic [DIGITS-1:0]   an_q, nxt_an;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [4*DIGITS-1:0] sh,
                                           input logic [IW-1:0] i);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < DIGITS; k++)
      if (IW'(k) == i) n = sh[4*k +: 4];
    return n;
  endfunction

  // True when every nibble from position i upward is zero (leading-zero run).
  function automatic logic upper_zero(input logic [4*DIGITS-1:0] sh,
                                      input logic [IW-1:0] i);
    logic z;
    z = 1'b1;
    for (int k = 0; k < DIGITS; k++)
      if ((IW'(k) >= i) && (sh[4*k +: 4] != 4'h0)) z = 1'b0;
    return z;
  endfunction

  assign tick    = s2 & ~s3;
  assign wrap    = (idx == IDX_LAST);
  assign adv_idx = wrap ? '0 : idx + IW'(1);

  always_comb begin
    nxt_state     = state;
    nxt_idx       = idx;
    nxt_cnt       = cnt;
    nxt_shadow    = shadow;
    nxt_dp_shadow = dp_shadow;
    nxt_ack       = 1'b0;
    nxt_frame     = 1'b0;
    nxt_an        = '1;
    nxt_seg       = 7'h7F;
    nxt_dp_out    = 1'b1;

    case (state)
      IDLE: begin
        if (tick) begin
          nxt_state = GUARD;
          nxt_cnt   = '0;
        end
      end
      GUARD, SHOW: begin
        if (tick) begin
          nxt_state = GUARD;
          nxt_cnt   = '0;
          nxt_idx   = adv_idx;
          if (wrap) begin
            nxt_frame = 1'b1;
            if (bus.LOAD) begin
              nxt_shadow    = bus.DATA;
              nxt_dp_shadow = bus.DP;
              nxt_ack       = 1'b1;
            end
          end
        end else if (state == GUARD) begin
          if (cnt == CNT_LAST) nxt_state = SHOW;
          else                 nxt_cnt   = cnt + CW'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    if (nxt_state == SHOW) begin
      nxt_an[nxt_idx] = 1'b0;
      nxt_dp_out      = ~nxt_dp_shadow[nxt_idx];
      if ((BLANK_LZ != 0) && (nxt_idx != '0) && upper_zero(nxt_shadow, nxt_idx))
        nxt_seg = 7'h7F;
      else
        nxt_seg = hex_to_seg(nibble_at(nxt_shadow, nxt_idx));
    end
  end

  // Stage p0: S_CLK synchroniser / edge history, FSM state and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      shadow    <= '0;
      dp_shadow <= '0;
      ack_q     <= 1'b0;
      frame_q   <= 1'b0;
      seg_q     <= 7'h7F;
      dp_out_q  <= 1'b1;
      an_q      <= '1;
    end else begin
      s1        <= bus.S_CLK;
      s2        <= s1;
      s3        <= s2;
      state     <= nxt_state;
      idx       <= nxt_idx;
      cnt       <= nxt_cnt;
      shadow    <= nxt_shadow;
      dp_shadow <= nxt_dp_shadow;
      ack_q     <= nxt_ack;
      frame_q   <= nxt_frame;
      seg_q     <= nxt_seg;
      dp_out_q  <= nxt_dp_out;
      an_q      <= nxt_an;
    end
  end

  assign bus.ACK    = ack_q;
  assign bus.FRAME  = frame_q;
  assign bus.SEG    = seg_q;
  assign bus.DP_OUT = dp_out_q;
  assign bus.AN     = an_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Randomised bench for seg7_scan: one instance with leading-zero blanking, one without,
// both compared against a digit-level model of the scan sequence.
module tb_seg7_scan;
  localparam int G = 4;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_chk  = 0;
  int   n_fail = 0;

  seg7_scan_if bus ();
  seg7_scan_if bus2 ();

  assign bus2.S_CLK = bus.S_CLK;
  assign bus2.DATA  = bus.DATA;
  assign bus2.DP    = bus.DP;
  assign bus2.LOAD  = bus.LOAD;

  seg7_scan #(.DIGITS(4), .GUARD_CYC(G), .BLANK_LZ(1)) dut  (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  seg7_scan #(.DIGITS(4), .GUARD_CYC(G), .BLANK_LZ(0)) dut2 (.CLK(CLK), .RST_N(RST_N), .bus(bus2));

  always #5 CLK = ~CLK;

  localparam logic [6:0] HEX_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: which digit is up, what the display holds, and what should be on the pins.
  bit          m_active;
  int          m_idx;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg, e_seg2;
  logic        e_dpo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] sh, input int i, input bit blz);
    logic [15:0] upper;
    upper = sh >> (4 * i);
    if (blz && i > 0 && upper == 16'h0) return 7'h7F;
    return HEX_TBL[upper[3:0]];
  endfunction

  task automatic model_reset();
    m_active = 0; m_idx = 0; m_sh = 16'h0; m_dp = 4'h0;
    e_an = 4'hF; e_seg = 7'h7F; e_seg2 = 7'h7F; e_dpo = 1'b1;
  endtask

  task automatic chk_display(input string tag);
    chk({tag, "_an"},   32'(bus.AN),      32'(e_an));
    chk({tag, "_seg"},  32'(bus.SEG),     32'(e_seg));
    chk({tag, "_dp"},   32'(bus.DP_OUT),  32'(e_dpo));
    chk({tag, "_seg2"}, 32'(bus2.SEG),    32'(e_seg2));
    chk({tag, "_an2"},  32'(bus2.AN),     32'(e_an));
    chk({tag, "_1hot"}, 32'($countones(~bus.AN) <= 1), 32'd1);
  endtask

  task automatic scramble_inputs();
    bus.DATA = 16'($urandom);
    bus.DP   = 4'($urandom);
    bus.LOAD = 1'($urandom);
  endtask

  // One S_CLK pulse: tick lands on the 3rd edge, then G guard cycles, then the new digit.
  task automatic scan_tick(input logic [15:0] data, input logic [3:0] dp, input logic load);
    bit e_frame, e_ack;
    @(negedge CLK);
    bus.DATA = data; bus.DP = dp; bus.LOAD = load; bus.S_CLK = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk_display("pre_tick");
    end
    e_frame = 0; e_ack = 0;
    if (!m_active) begin
      m_active = 1; m_idx = 0;
    end else begin
      e_frame = (m_idx == 3);
      e_ack   = e_frame && load;
      if (e_ack) begin m_sh = data; m_dp = dp; end
      m_idx = (m_idx + 1) % 4;
    end
    e_an = 4'hF; e_seg = 7'h7F; e_seg2 = 7'h7F; e_dpo = 1'b1;
    @(negedge CLK);
    chk("frame", 32'(bus.FRAME), 32'(e_frame));
    chk("ack",   32'(bus.ACK),   32'(e_ack));
    chk("ack2",  32'(bus2.ACK),  32'(e_ack));
    chk_display("guard0");
    bus.LOAD = 1'($urandom);
    for (int k = 1; k < G; k++) begin
      @(negedge CLK);
      chk("frame_1cyc", 32'(bus.FRAME), 32'd0);
      chk("ack_1cyc",   32'(bus.ACK),   32'd0);
      chk_display("guard");
    end
    e_an   = ~(4'b0001 << m_idx);
    e_seg  = exp_seg(m_sh, m_idx, 1'b1);
    e_seg2 = exp_seg(m_sh, m_idx, 1'b0);
    e_dpo  = ~m_dp[m_idx];
    @(negedge CLK);
    chk_display("show");
    repeat ($urandom_range(1, 5)) begin
      scramble_inputs();
      @(negedge CLK);
      chk_display("hold_hi");
    end
    bus.S_CLK = 1'b0;
    repeat ($urandom_range(2, 5)) begin
      scramble_inputs();
      @(negedge CLK);
      chk_display("hold_lo");
    end
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    return 16'($urandom) & masks[$urandom_range(0, 4)];
  endfunction

  initial begin
    bus.S_CLK = 1'b0; bus.DATA = 16'h0; bus.DP = 4'h0; bus.LOAD = 1'b0;
    RST_N = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_ack",   32'(bus.ACK),   32'd0);
    chk("rst_frame", 32'(bus.FRAME), 32'd0);
    chk_display("rst");
    RST_N = 1'b1;
    repeat (4) begin
      scramble_inputs();
      @(negedge CLK);
      chk_display("post_rst");
    end

    for (int i = 0; i < 8; i++) scan_tick(16'($urandom), 4'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) scan_tick(16'h12AF, 4'b0101, 1'b1);
    for (int i = 0; i < 8; i++) scan_tick(16'h0050, 4'b0010, 1'b1);
    for (int i = 0; i < 48; i++) scan_tick(rand_data(), 4'($urandom), 1'($urandom));

    for (int k = 0; k < 4 && !(m_active && m_idx == 2); k++)
      scan_tick(rand_data(), 4'($urandom), 1'b0);
    chk("at_digit2", 32'(m_idx), 32'd2);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    chk("async_rst_ack", 32'(bus.ACK), 32'd0);
    chk_display("async_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) scan_tick(rand_data(), 4'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
